// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-index width, hazard FSM states and
// the bundle of hazard control outputs.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic bubble_idex;
        logic flush_ifid;
        logic flush_idex;
        logic stall_all;
    } hazard_ctrl_t;

    // A load only creates a hazard when it really writes a non-zero register
    // that the decoding instruction actually reads.
    function automatic logic load_use_hit(
        input logic                  mem_read,
        input logic                  wreg,
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  use_rs1,
        input logic [REG_ADDR_W-1:0] addr1,
        input logic                  use_rs2,
        input logic [REG_ADDR_W-1:0] addr2
    );
        logic rd_valid;
        rd_valid = mem_read & wreg & (rd != {REG_ADDR_W{1'b0}});
        return rd_valid & ((use_rs1 & (addr1 == rd)) | (use_rs2 & (addr2 == rd)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;

    // Count qualifying cycles, holding once the top value is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory
// wait handling with a timeout error, and stall/flush performance counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] addr1DEC,
    input  logic [REG_ADDR_W-1:0] addr2DEC,
    input  logic                  useRs1DEC,
    input  logic                  useRs2DEC,
    input  logic [REG_ADDR_W-1:0] rdEXE,
    input  logic                  WregEXE,
    input  logic                  memReadEXE,
    input  logic                  branchTakenEXE,
    input  logic                  memReqMEM,
    input  logic                  memAckMEM,
    output logic                  stallPC,
    output logic                  stallIFID,
    output logic                  bubbleIDEX,
    output logic                  flushIFID,
    output logic                  flushIDEX,
    output logic                  stallAll,
    output logic                  memErr,
    output logic [CNT_W-1:0]      stallCycles,
    output logic [CNT_W-1:0]      flushCount
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

    hazard_state_t     state_r;
    hazard_state_t     cur_state_s;
    hazard_state_t     state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_err_r;
    logic              mem_wait_s;
    logic              load_use_s;
    hazard_ctrl_t      ctrl_s;

    // While reset is held the control outputs behave as if in RUN.
    assign cur_state_s = rst ? RUN : state_r;

    assign load_use_s = load_use_hit(memReadEXE, WregEXE, rdEXE,
                                     useRs1DEC, addr1DEC, useRs2DEC, addr2DEC);

    // Memory-wait state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait-cycle counter: held at zero in RUN so MEM_WAIT always starts from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (state_r == RUN) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (state_r == MEM_WAIT) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky timeout flag, raised on the edge that enters ERROR.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err_r <= 1'b0;
        end else if (state_next_s == ERROR) begin
            mem_err_r <= 1'b1;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end

    // Next state and memory-wait decode.
    always_comb begin
        state_next_s = cur_state_s;
        mem_wait_s   = 1'b0;
        case (cur_state_s)
            RUN: begin
                mem_wait_s = memReqMEM & ~memAckMEM;
                if (memReqMEM && !memAckMEM) begin
                    state_next_s = MEM_WAIT;
                end else begin
                    state_next_s = RUN;
                end
            end
            MEM_WAIT: begin
                mem_wait_s = ~memAckMEM;
                if (memAckMEM) begin
                    state_next_s = RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = ERROR;
                end else begin
                    state_next_s = MEM_WAIT;
                end
            end
            ERROR: begin
                mem_wait_s   = 1'b1;
                state_next_s = ERROR;
            end
            default: begin
                mem_wait_s   = 1'b1;
                state_next_s = ERROR;
            end
        endcase
    end

    // Prioritised control: memory wait beats branch flush beats load-use stall.
    always_comb begin
        ctrl_s = '0;
        if (mem_wait_s) begin
            ctrl_s.stall_all = 1'b1;
        end else if (branchTakenEXE) begin
            ctrl_s.flush_ifid = 1'b1;
            ctrl_s.flush_idex = 1'b1;
        end else if (load_use_s) begin
            ctrl_s.stall_pc    = 1'b1;
            ctrl_s.stall_ifid  = 1'b1;
            ctrl_s.bubble_idex = 1'b1;
        end else begin
            ctrl_s = '0;
        end
    end

    assign stallPC    = ctrl_s.stall_pc;
    assign stallIFID  = ctrl_s.stall_ifid;
    assign bubbleIDEX = ctrl_s.bubble_idex;
    assign flushIFID  = ctrl_s.flush_ifid;
    assign flushIDEX  = ctrl_s.flush_idex;
    assign stallAll   = ctrl_s.stall_all;
    assign memErr     = mem_err_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl_s.stall_all | ctrl_s.stall_pc),
        .count (stallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl_s.flush_idex),
        .count (flushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (short timeout/narrow counters and
// defaults) driven by directed cases then random traffic against a reference model.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] addr1DEC, addr2DEC, rdEXE;
    logic       useRs1DEC, useRs2DEC, WregEXE, memReadEXE, branchTakenEXE;
    logic       memReqMEM, memAckMEM;

    logic        s_pc [2];
    logic        s_ifid [2];
    logic        b_idex [2];
    logic        f_ifid [2];
    logic        f_idex [2];
    logic        s_all [2];
    logic        m_err [2];
    logic [3:0]  sc0, fc0;
    logic [31:0] sc1, fc1;

    int checks = 0;
    int passes = 0;

    int     m_mode [2];
    int     m_wait [2];
    longint m_sc [2];
    longint m_fc [2];
    int     m_to [2]  = '{4, 255};
    longint m_max [2] = '{64'd15, 64'hFFFF_FFFF};

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst), .addr1DEC(addr1DEC), .addr2DEC(addr2DEC),
        .useRs1DEC(useRs1DEC), .useRs2DEC(useRs2DEC), .rdEXE(rdEXE),
        .WregEXE(WregEXE), .memReadEXE(memReadEXE), .branchTakenEXE(branchTakenEXE),
        .memReqMEM(memReqMEM), .memAckMEM(memAckMEM),
        .stallPC(s_pc[0]), .stallIFID(s_ifid[0]), .bubbleIDEX(b_idex[0]),
        .flushIFID(f_ifid[0]), .flushIDEX(f_idex[0]), .stallAll(s_all[0]),
        .memErr(m_err[0]), .stallCycles(sc0), .flushCount(fc0)
    );

    hazard_unit u1 (
        .clk(clk), .rst(rst), .addr1DEC(addr1DEC), .addr2DEC(addr2DEC),
        .useRs1DEC(useRs1DEC), .useRs2DEC(useRs2DEC), .rdEXE(rdEXE),
        .WregEXE(WregEXE), .memReadEXE(memReadEXE), .branchTakenEXE(branchTakenEXE),
        .memReqMEM(memReqMEM), .memAckMEM(memAckMEM),
        .stallPC(s_pc[1]), .stallIFID(s_ifid[1]), .bubbleIDEX(b_idex[1]),
        .flushIFID(f_ifid[1]), .flushIDEX(f_idex[1]), .stallAll(s_all[1]),
        .memErr(m_err[1]), .stallCycles(sc1), .flushCount(fc1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected {stallPC,stallIFID,bubbleIDEX,flushIFID,flushIDEX,stallAll}.
    function automatic logic [5:0] model_ctrl(input int i);
        int mode = rst ? 0 : m_mode[i];
        bit lu = memReadEXE && WregEXE && (rdEXE != 5'd0) &&
                 ((useRs1DEC && addr1DEC == rdEXE) || (useRs2DEC && addr2DEC == rdEXE));
        bit mw = (mode == 2) || (mode == 1 && !memAckMEM) ||
                 (mode == 0 && memReqMEM && !memAckMEM);
        if (mw) return 6'b000001;
        if (branchTakenEXE) return 6'b000110;
        if (lu) return 6'b111000;
        return 6'b000000;
    endfunction

    task automatic model_clock();
        logic [5:0] c [2];
        for (int i = 0; i < 2; i++) c[i] = model_ctrl(i);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = 0; m_wait[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else begin
                if ((c[i][5] || c[i][0]) && m_sc[i] < m_max[i]) m_sc[i]++;
                if (c[i][1] && m_fc[i] < m_max[i]) m_fc[i]++;
                if (m_mode[i] == 0) begin
                    if (memReqMEM && !memAckMEM) begin m_mode[i] = 1; m_wait[i] = 0; end
                end else if (m_mode[i] == 1) begin
                    if (memAckMEM) m_mode[i] = 0;
                    else if (m_wait[i] == m_to[i] - 1) m_mode[i] = 2;
                    else m_wait[i]++;
                end
            end
        end
    endtask

    // Compare both instances against the model, then advance one clock.
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("ctrl%0d", i),
                      {26'd0, s_pc[i], s_ifid[i], b_idex[i], f_ifid[i], f_idex[i], s_all[i]},
                      {26'd0, model_ctrl(i)});
            check_val($sformatf("memErr%0d", i), {31'd0, m_err[i]}, {31'd0, m_mode[i] == 2});
        end
        check_val("stallCycles0", {28'd0, sc0}, m_sc[0][31:0]);
        check_val("flushCount0", {28'd0, fc0}, m_fc[0][31:0]);
        check_val("stallCycles1", sc1, m_sc[1][31:0]);
        check_val("flushCount1", fc1, m_fc[1][31:0]);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        addr1DEC = 5'd0; addr2DEC = 5'd0; rdEXE = 5'd0;
        useRs1DEC = 1'b0; useRs2DEC = 1'b0; WregEXE = 1'b0; memReadEXE = 1'b0;
        branchTakenEXE = 1'b0; memReqMEM = 1'b0; memAckMEM = 1'b0;
    endtask

    task automatic load_x5();
        memReadEXE = 1'b1; WregEXE = 1'b1; rdEXE = 5'd5;
        addr2DEC = 5'd5; useRs2DEC = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_wait[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        idle();
        rst = 1'b1;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        #1;
        check_val("rst_sc", {28'd0, sc0}, 32'd0);
        check_val("rst_err", {31'd0, m_err[0]}, 32'd0);
        check_val("rst_stall", {31'd0, s_all[0]}, 32'd0);

        // Load-use on rs2: one stall cycle, counted once.
        load_x5();
        #1;
        check_val("lu_stallPC", {31'd0, s_pc[0]}, 32'd1);
        check_val("lu_bubble", {31'd0, b_idex[0]}, 32'd1);
        tick();
        idle();
        #1;
        check_val("lu_one_cycle", {31'd0, s_pc[0]}, 32'd0);
        check_val("lu_sc", sc1, 32'd1);

        // rd=x0 or rs2 unused: no hazard.
        load_x5(); rdEXE = 5'd0; addr2DEC = 5'd0;
        #1;
        check_val("rd0_nostall", {31'd0, s_pc[0]}, 32'd0);
        tick();
        load_x5(); useRs2DEC = 1'b0;
        #1;
        check_val("unused_nostall", {31'd0, s_pc[0]}, 32'd0);
        tick();

        // Branch overrides load-use.
        load_x5(); branchTakenEXE = 1'b1;
        #1;
        check_val("br_flush", {30'd0, f_ifid[0], f_idex[0]}, 32'd3);
        check_val("br_nostall", {31'd0, s_pc[0]}, 32'd0);
        tick();
        idle();
        #1;
        check_val("br_fc", {28'd0, fc0}, 32'd1);

        // Three-cycle memory wait.
        rst = 1'b1; tick(); rst = 1'b0;
        memReqMEM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("mw_stall", {31'd0, s_all[1]}, 32'd1);
            tick();
        end
        memAckMEM = 1'b1;
        #1;
        check_val("mw_ack_nostall", {31'd0, s_all[1]}, 32'd0);
        tick();
        idle();
        #1;
        check_val("mw_sc", sc1, 32'd3);
        check_val("mw_run", {31'd0, s_all[1]}, 32'd0);

        // Zero-wait access.
        memReqMEM = 1'b1; memAckMEM = 1'b1;
        #1;
        check_val("zw_nostall", {31'd0, s_all[0]}, 32'd0);
        tick();
        idle();
        #1;
        check_val("zw_run", {31'd0, s_all[0]}, 32'd0);

        // Timeout on u0 (MEM_TIMEOUT=4): RUN + four MEM_WAIT cycles, then ERROR.
        rst = 1'b1; tick(); rst = 1'b0;
        memReqMEM = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        #1;
        check_val("to_not_yet", {31'd0, m_err[0]}, 32'd0);
        tick();
        #1;
        check_val("to_err", {31'd0, m_err[0]}, 32'd1);
        check_val("to_err_u1", {31'd0, m_err[1]}, 32'd0);
        memAckMEM = 1'b1;
        tick();
        #1;
        check_val("late_ack_err", {31'd0, m_err[0]}, 32'd1);
        check_val("late_ack_stall", {31'd0, s_all[0]}, 32'd1);
        memAckMEM = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rst_comb_run", {31'd0, s_all[0]}, 32'd1);
        tick();
        rst = 1'b0;
        idle();
        #1;
        check_val("rst_err_clr", {31'd0, m_err[0]}, 32'd0);
        check_val("rst_sc_clr", {28'd0, sc0}, 32'd0);
        check_val("rst_fc_clr", {28'd0, fc0}, 32'd0);
        check_val("rst_run", {31'd0, s_all[0]}, 32'd0);

        // Saturation: 20 stall cycles on a 4-bit counter.
        memReqMEM = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check_val("sat_sc0", {28'd0, sc0}, 32'd15);
        check_val("sat_sc1", sc1, 32'd20);

        // Random traffic against the model.
        rst = 1'b1; idle(); tick();
        for (int k = 0; k < 600; k++) begin
            rst            = ($urandom_range(0, 39) == 0);
            addr1DEC       = 5'($urandom_range(0, 7));
            addr2DEC       = 5'($urandom_range(0, 7));
            rdEXE          = 5'($urandom_range(0, 7));
            useRs1DEC      = 1'($urandom_range(0, 1));
            useRs2DEC      = 1'($urandom_range(0, 1));
            WregEXE        = ($urandom_range(0, 3) != 0);
            memReadEXE     = 1'($urandom_range(0, 1));
            branchTakenEXE = ($urandom_range(0, 5) == 0);
            memReqMEM      = ($urandom_range(0, 3) == 0);
            memAckMEM      = 1'($urandom_range(0, 1));
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
